// File: rtl/cnn_comp_parallel.sv
// cnn_comp_parallel: dual-kernel 3x3 convolution over a constant 5x5 image, multiplier-free, saturated to 12 bits.
module cnn_comp_parallel #(
  parameter logic [224:0] IMG = {9'd12, 9'd11, 9'd10, 9'd9, 9'd8, 9'd7, 9'd6, 9'd5, 9'd4,
                                 9'd3, 9'd2, 9'd1, 9'd0, 9'h1ff, 9'h1fe, 9'h1fd, 9'h1fc,
                                 9'h1fb, 9'h1fa, 9'h1f9, 9'h1f8, 9'h1f7, 9'h1f6, 9'h1f5, 9'h1f4},
  parameter logic [17:0]  K1  = {9{2'b01}},
  parameter logic [17:0]  K2  = {3{6'b110001}}
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic signed [11:0] OR1_0, OR1_1, OR1_2, OR1_3, OR1_4, OR1_5, OR1_6, OR1_7, OR1_8,
  output logic signed [11:0] OR2_0, OR2_1, OR2_2, OR2_3, OR2_4, OR2_5, OR2_6, OR2_7, OR2_8
);
  // 14-bit terms keep -(-256) and -2*(-256) exact, and nine of them cannot overflow
  function automatic logic signed [13:0] term(input logic [1:0] w, input logic signed [8:0] a);
    logic signed [13:0] e;
    e = a;
    return w == 2'b01 ? e : w == 2'b11 ? -e : w == 2'b10 ? -(e <<< 1) : 14'sd0;
  endfunction

  function automatic logic signed [13:0] conv(input logic [17:0] k, input int r, input int c);
    logic signed [13:0] s;
    s = 14'sd0;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++)
        s = s + term(k[2*(3*y+x) +: 2], IMG[9*(5*(r+y)+c+x) +: 9]);
    return s;
  endfunction

  function automatic logic [11:0] sat(input logic signed [13:0] s);
    return s > 14'sd2047 ? 12'h7ff : s < -14'sd2048 ? 12'h800 : s[11:0];
  endfunction

  logic [8:0][11:0] s1, s2, or1_q, or2_q;

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      assign s1[3*r+c] = sat(conv(K1, r, c));
      assign s2[3*r+c] = sat(conv(K2, r, c));
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      or1_q <= '0;
      or2_q <= '0;
    end else begin
      or1_q <= s1;
      or2_q <= s2;
    end

  assign OR1_0 = or1_q[0];
  assign OR1_1 = or1_q[1];
  assign OR1_2 = or1_q[2];
  assign OR1_3 = or1_q[3];
  assign OR1_4 = or1_q[4];
  assign OR1_5 = or1_q[5];
  assign OR1_6 = or1_q[6];
  assign OR1_7 = or1_q[7];
  assign OR1_8 = or1_q[8];
  assign OR2_0 = or2_q[0];
  assign OR2_1 = or2_q[1];
  assign OR2_2 = or2_q[2];
  assign OR2_3 = or2_q[3];
  assign OR2_4 = or2_q[4];
  assign OR2_5 = or2_q[5];
  assign OR2_6 = or2_q[6];
  assign OR2_7 = or2_q[7];
  assign OR2_8 = or2_q[8];
endmodule

// File: tb/tb_cnn_comp_parallel.sv
// tb_cnn_comp_parallel: five engine instances with distinct images/kernels, checked against an arithmetic model under random async resets.
module tb_cnn_comp_parallel;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  function automatic logic [224:0] fill_img(input int mode);
    logic [224:0] img;
    int v;
    img = '0;
    for (int k = 0; k < 25; k++) begin
      v = mode == 0 ? k - 12 : mode == 1 ? 255 : mode == 2 ? -256 :
          k % 5 == 0 ? -256 : k % 7 == 0 ? 255 : (k * 37) % 200 - 100;
      img[9*k +: 9] = 9'(v);
    end
    return img;
  endfunction

  localparam logic [17:0] K_MIX1 = {2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
  localparam logic [17:0] K_MIX2 = {2'b01, 2'b10, 2'b10, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10, 2'b01};
  localparam logic [224:0] IMGS [5] = '{fill_img(0), fill_img(1), fill_img(2), fill_img(0), fill_img(3)};
  localparam logic [17:0] K1S [5] = '{{9{2'b01}}, {9{2'b10}}, 18'h0, 18'h00200, K_MIX1};
  localparam logic [17:0] K2S [5] = '{{3{6'b110001}}, {9{2'b01}}, {9{2'b11}}, K_MIX1, K_MIX2};

  wire signed [11:0] o1 [5][9];
  wire signed [11:0] o2 [5][9];

  cnn_comp_parallel u_def (
    .clk(clk), .rst_n(rst_n),
    .OR1_0(o1[0][0]), .OR1_1(o1[0][1]), .OR1_2(o1[0][2]), .OR1_3(o1[0][3]), .OR1_4(o1[0][4]),
    .OR1_5(o1[0][5]), .OR1_6(o1[0][6]), .OR1_7(o1[0][7]), .OR1_8(o1[0][8]),
    .OR2_0(o2[0][0]), .OR2_1(o2[0][1]), .OR2_2(o2[0][2]), .OR2_3(o2[0][3]), .OR2_4(o2[0][4]),
    .OR2_5(o2[0][5]), .OR2_6(o2[0][6]), .OR2_7(o2[0][7]), .OR2_8(o2[0][8])
  );

  for (genvar i = 1; i < 5; i++) begin : g_dut
    cnn_comp_parallel #(.IMG(IMGS[i]), .K1(K1S[i]), .K2(K2S[i])) u_dut (
      .clk(clk), .rst_n(rst_n),
      .OR1_0(o1[i][0]), .OR1_1(o1[i][1]), .OR1_2(o1[i][2]), .OR1_3(o1[i][3]), .OR1_4(o1[i][4]),
      .OR1_5(o1[i][5]), .OR1_6(o1[i][6]), .OR1_7(o1[i][7]), .OR1_8(o1[i][8]),
      .OR2_0(o2[i][0]), .OR2_1(o2[i][1]), .OR2_2(o2[i][2]), .OR2_3(o2[i][3]), .OR2_4(o2[i][4]),
      .OR2_5(o2[i][5]), .OR2_6(o2[i][6]), .OR2_7(o2[i][7]), .OR2_8(o2[i][8])
    );
  end

  // plain signed multiply-accumulate then clamp
  function automatic int model(input logic [224:0] img, input logic [17:0] k, input int n);
    int s;
    int r;
    int c;
    logic signed [1:0] w;
    logic signed [8:0] a;
    s = 0;
    r = n / 3;
    c = n % 3;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++) begin
        w = k[2*(3*y+x) +: 2];
        a = img[9*(5*(r+y)+c+x) +: 9];
        s += int'(w) * int'(a);
      end
    return s > 2047 ? 2047 : s < -2048 ? -2048 : s;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
    total++;
    if (got !== 32'(exp)) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string phase, input bit zero);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 9; j++) begin
        chk($sformatf("%s u%0d OR1_%0d", phase, i, j), 32'(o1[i][j]), zero ? 0 : model(IMGS[i], K1S[i], j));
        chk($sformatf("%s u%0d OR2_%0d", phase, i, j), 32'(o2[i][j]), zero ? 0 : model(IMGS[i], K2S[i], j));
      end
  endtask

  int plan1 [9] = '{-54, -45, -36, -9, 0, 9, 36, 45, 54};
  int plan3 [9] = '{12, 10, 8, 2, 0, -2, -8, -10, -12};

  initial begin
    repeat (3) @(posedge clk);
    #1 check_all("reset", 1'b1);
    @(negedge clk);
    #($urandom_range(1, 3)) rst_n = 1'b1;
    #1 check_all("pre_edge", 1'b1);
    @(posedge clk);
    #1 check_all("first", 1'b0);
    for (int j = 0; j < 9; j++) begin
      chk($sformatf("plan def OR1_%0d", j), 32'(o1[0][j]), plan1[j]);
      chk($sformatf("plan def OR2_%0d", j), 32'(o2[0][j]), -6);
      chk($sformatf("plan 255x-2 OR1_%0d", j), 32'(o1[1][j]), -2048);
      chk($sformatf("plan 255x1 OR2_%0d", j), 32'(o2[1][j]), 2047);
      chk($sformatf("plan -256x0 OR1_%0d", j), 32'(o1[2][j]), 0);
      chk($sformatf("plan -256x-1 OR2_%0d", j), 32'(o2[2][j]), 2047);
      chk($sformatf("plan center OR1_%0d", j), 32'(o1[3][j]), plan3[j]);
    end
    for (int it = 0; it < 20; it++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #($urandom_range(1, 8)) rst_n = 1'b0;
      #1 check_all("async_clr", 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1 check_all("held", 1'b1);
      @(posedge clk);
      #($urandom_range(1, 8)) rst_n = 1'b1;
      #1 check_all("released", 1'b1);
      @(posedge clk);
      #1 check_all("reload", 1'b0);
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1 check_all("hold", 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cnn_comp_parallel.md
Name: cnn_comp_parallel

Overview:
- Multiplier-free dual-kernel 3x3 convolution engine for the CNN datapath.
- Holds a constant 5x5 signed image and two 3x3 ternary/2-bit signed kernels.
- Both kernels are applied in parallel over all nine valid (stride 1, no padding) window positions.
- Products come from weight-decoded select/negate/shift logic ("comparator" decode), not multipliers.
- Result: two 3x3 feature maps of saturated 12-bit signed values, registered on the clock.

Parameters:
- IMG, 225 bits, default pixel a_k = k-12 for k=0..24: packed 5x5 image, row-major; a_k in bits [9k+8:9k], 9-bit signed; a0 is top-left.
- K1, 18 bits, default all weights 2'b01 (+1): kernel 1; w_i in bits [2i+1:2i], 2-bit signed, i row-major.
- K2, 18 bits, default w0=w3=w6=+1 (01), w2=w5=w8=-1 (11), w1=w4=w7=0 (00): kernel 2, same packing as K1.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- OR1_0..OR1_8  out  12 each, signed  kernel-1 feature map; OR1_(3r+c) is window row r, column c (r,c = 0..2).
- OR2_0..OR2_8  out  12 each, signed  kernel-2 feature map, same indexing.

Behaviour:
- Window (r,c) covers pixels a_(5(r+y)+(c+x)) for y,x = 0..2, paired with weight w_(3y+x).
- Weight decode, with no multiplier inferred:
  - 00 -> 0
  - 01 -> +a
  - 11 -> -a
  - 10 -> -2a (negate and left shift)
- Each term is sign-extended to at least 14 bits before summing.
- Each output is the sum of its 9 terms, computed at full precision with no intermediate wrap.
- Saturation to 12-bit signed range:
  - sum > 2047 -> 2047
  - sum < -2048 -> -2048
  - otherwise the exact value.
- All 18 results are computed combinationally in parallel and captured in output registers on each rising clk edge.
- Reset:
  - rst_n low -> all 18 outputs forced to 0 immediately, without waiting for a clk edge.
  - While rst_n is low, outputs stay 0 regardless of clk.
- Latency: valid results appear on the first rising clk edge after rst_n deasserts. Outputs then hold constant, since image and weights are constant.
- Reset asserted mid-operation: outputs clear asynchronously and reload on the first edge after release. No other state is held.
- Asymmetric edge values:
  - -2a with a = -256 gives +512.
  - -a with a = -256 gives +256. This is representable because of the widened term width.

Test Plan:
- Defaults; hold rst_n=0 for 3 cycles -> all outputs 0. Release -> after first rising edge, OR1_0..8 = -54,-45,-36,-9,0,9,36,45,54 and OR2_0..8 = -6 (all nine).
- Reset reassert mid-run (async, between edges) -> all outputs 0 before the next edge. Release -> default values return after one edge.
- IMG all 255, K1 all 01 -> OR1_* = 2047 (sum 2295 saturates).
- IMG all 255, K1 all 10 (-2) -> OR1_* = -2048 (sum -4590 saturates).
- IMG all -256, K2 all 11 -> OR2_* = 2047 (sum 2304 saturates). Same image with K1 all 00 -> OR1_* = 0.
- IMG a_k = k-12, K1 with only w4 = 10 (center weight -2) -> OR1_0..8 = 12,10,8,2,0,-2,-8,-10,-12.
